mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//   Memory-stage load/store unit. It sits directly downstream of the E/M control/data pipeline register.
//   It consumes that register's M-stage outputs and runs one data-memory transaction per load/store over a req/gnt/rvalid bus.
//   While the transaction is in flight it holds StallM. It produces aligned, extended ReadDataM for the M/W register.
// PARAMETERS
//   TIMEOUT_CYCLES  255  cycles spent in REQ+WAIT before the access is aborted with BusErrM
//   CNT_W           8    timeout counter width; must satisfy TIMEOUT_CYCLES < 2**CNT_W
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous reset, active-high
//   ResultSrcM   in   2   2'b01 = load; any other value = no load
//   MemWriteM    in   1   store request
//   funct3M      in   3   000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//   ALUResultM   in   32  effective byte address
//   WriteDataM   in   32  store data, right-aligned
//   dmem_req     out  1   bus request
//   dmem_we      out  1   1 = store
//   dmem_addr    out  32  {ALUResultM[31:2],2'b00}
//   dmem_wdata   out  32  store data shifted into byte lanes
//   dmem_wstrb   out  4   byte-lane enables; 4'b0000 on loads
//   dmem_gnt     in   1   request accepted this cycle
//   dmem_rvalid  in   1   load data valid this cycle
//   dmem_rdata   in   32  load word
//   StallM       out  1   pipeline stall (F/D/E/M hold)
//   ReadDataM    out  32  load result, extended per funct3M
//   AccessFaultM out  1   misaligned or illegal-funct3 access; no bus cycle issued
//   BusErrM      out  1   timeout abort; one-cycle pulse in DONE
// BEHAVIOUR
//   Access signals:
//   - acc = (ResultSrcM==2'b01) | MemWriteM.
//   - fault when either holds:
//     - funct3M is 011, 110 or 111.
//     - The address is misaligned: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
//   FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
//   - IDLE, acc & ~fault:
//     - dmem_req=1 (combinational) and StallM=1.
//     - If gnt: store -> DONE, load -> WAIT.
//     - Otherwise -> REQ.
//   - IDLE, acc & fault:
//     - No request. AccessFaultM=1 for that cycle, StallM=0. Stay in IDLE.
//   - REQ:
//     - dmem_req=1, StallM=1; address/data/strobe held from the live M inputs, which are stable under stall.
//     - On gnt: store -> DONE, load -> WAIT.
//   - WAIT:
//     - StallM=1. On rvalid, capture the extended data into rd_q -> DONE.
//     - rvalid is only honoured in WAIT; it is ignored in every other state, including the gnt cycle.
//   - DONE:
//     - StallM=0 and ReadDataM=rd_q; the pipeline advances on this edge -> IDLE.
//     - No re-issue, even though acc is still high.
//   Timeout:
//   - The counter clears on entry to REQ/WAIT and increments each cycle spent there.
//   - When count==TIMEOUT_CYCLES-1 and no gnt/rvalid arrives: -> DONE with rd_q=0 and BusErrM=1 in DONE.
//   Store lanes:
//   - SB: wstrb=4'b0001<<a[1:0], wdata={4{wd[7:0]}}.
//   - SH: wstrb=a[1]?1100:0011, wdata={2{wd[15:0]}}.
//   - SW: wstrb=1111, wdata=wd.
//   Load extract:
//   - Byte/half is selected by a[1:0].
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//   Latency with a zero-wait bus (gnt in the issue cycle, rvalid the cycle after):
//   - Store: 1 stall cycle.
//   - Load: 2 stall cycles, with data presented in DONE.
//   Outputs outside active states:
//   - dmem_we, dmem_wdata and dmem_wstrb are 0 whenever dmem_req=0.
//   - ReadDataM=0 outside DONE.
//   Reset values: all outputs 0, rd_q=0, counter=0, state=IDLE.
//   Reset asserted mid-transaction:
//   - Immediate return to IDLE; dmem_req, StallM and the fault/error outputs are forced to 0 while reset=1.
//   - A pending rvalid after reset release is ignored.
// TESTING
//   1. SW a=0x100, wd=0xDEADBEEF, gnt in issue cycle -> wstrb=1111, StallM high 1 cycle, then DONE->IDLE.
//   2. SB a=0x103, wd=0x000000AB -> wdata=0xABABABAB, wstrb=1000. LB at the same address with rdata=0xAB000000 -> ReadDataM=0xFFFFFFAB; LBU -> 0x000000AB.
//   3. LH a=0x102, gnt after 3 cycles, rvalid 2 cycles later, rdata=0x8001xxxx -> StallM high for 6 cycles, ReadDataM=0xFFFF8001 in DONE.
//   4. LW a=0x101 -> no dmem_req, AccessFaultM=1, StallM=0. funct3=011 -> same response.
//   5. LW issued with gnt=0 held for 255 cycles -> BusErrM pulse, ReadDataM=0, StallM drops. A stray rvalid in IDLE is ignored.
//   6. reset raised while in WAIT -> dmem_req/StallM=0 immediately, state IDLE. A late rvalid after release is ignored.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one req/gnt/rvalid data-memory transaction per
// load or store, stalls the pipeline while it is in flight, and returns extended load data.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        AccessFaultM,
  output logic        BusErrM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic             err_q, err_d;

  logic is_load_s, acc_s, fault_s, tmo_s;
  logic req_s, stall_s, afault_s;

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b100:  load_extract = {24'h000000, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b101:  load_extract = {16'h0000, h};
      3'b010:  load_extract = w;
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   store_strobe = 4'b0001 << off;
      2'b01:   store_strobe = off[1] ? 4'b1100 : 4'b0011;
      default: store_strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   store_lanes = {4{wd[7:0]}};
      2'b01:   store_lanes = {2{wd[15:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  assign is_load_s = (ResultSrcM == 2'b01);
  assign acc_s     = is_load_s | MemWriteM;
  assign fault_s   = (funct3M == 3'b011) | (funct3M == 3'b110) | (funct3M == 3'b111) |
                     ((funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                     ((funct3M[1:0] == 2'b10) & (ALUResultM[1:0] != 2'b00));
  assign tmo_s     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state, timeout counter and load-capture logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    err_d    = 1'b0;
    req_s    = 1'b0;
    stall_s  = 1'b0;
    afault_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (acc_s && !fault_s) begin
          req_s   = 1'b1;
          stall_s = 1'b1;
          rd_d    = 32'h0000_0000;
          cnt_d   = '0;
          if (dmem_gnt) begin
            state_d = MemWriteM ? S_DONE : S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end else if (acc_s) begin
          afault_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (dmem_gnt) begin
          state_d = MemWriteM ? S_DONE : S_WAIT;
          cnt_d   = '0;
        end else if (tmo_s) begin
          state_d = S_DONE;
          rd_d    = 32'h0000_0000;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT: begin
        stall_s = 1'b1;
        if (dmem_rvalid) begin
          rd_d    = load_extract(funct3M, ALUResultM[1:0], dmem_rdata);
          state_d = S_DONE;
        end else if (tmo_s) begin
          state_d = S_DONE;
          rd_d    = 32'h0000_0000;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counter, captured data and error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_q    <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Outputs are forced quiet while reset is held, even mid-transaction
  assign dmem_req     = req_s & ~reset;
  assign dmem_we      = dmem_req & MemWriteM;
  assign dmem_addr    = reset ? 32'h0000_0000 : {ALUResultM[31:2], 2'b00};
  assign dmem_wdata   = dmem_we ? store_lanes(funct3M[1:0], WriteDataM) : 32'h0000_0000;
  assign dmem_wstrb   = dmem_we ? store_strobe(funct3M[1:0], ALUResultM[1:0]) : 4'b0000;
  assign StallM       = stall_s & ~reset;
  assign ReadDataM    = ((state_q == S_DONE) && !reset) ? rd_q : 32'h0000_0000;
  assign AccessFaultM = afault_s & ~reset;
  assign BusErrM      = (state_q == S_DONE) & err_q & ~reset;

endmodule
